pipeline_hazard_ctrl: RTL

Hazard and sequencing controller for the 5-stage pipeline: produces the enable and synchronous-clear strobes for the F/D, D/E, E/M and M/W pipeline registers and the PC enable. It resolves load-use stalls, branch/jump redirect flushes, instruction-fetch bubbles and multi-cycle data-memory waits, with a watchdog on the memory wait. It sits beside the datapath and drives the `en`/`sclr` pins of every inter-stage register.

---
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stage enables, sync clears, PC enable, dmem watchdog.
// Optional performance counters (stall_cyc, flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic [4:0]  rdE,
  input  logic        memreadE,
  input  logic        redirectE,
  input  logic        imem_validF,
  input  logic        dmem_reqM,
  input  logic        dmem_ackM,
  output logic        pc_en,
  output logic        enFD,
  output logic        sclrFD,
  output logic        enDE,
  output logic        sclrDE,
  output logic        enEM,
  output logic        sclrEM,
  output logic        enMW,
  output logic        sclrMW,
  output logic        mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cyc,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, MEMWAIT} state_t;

  localparam logic [7:0] TO = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wd_q, wd_d;
  logic       pend_q, pend_d;

  logic load_use, mem_wait, wd_hit;
  logic do_freeze, do_run, redir, redir_app;

  assign load_use = memreadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
  assign mem_wait = dmem_reqM && !dmem_ackM;
  assign wd_hit   = (wd_q == TO);

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= BOOT;
      wd_q    <= 8'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      pend_q  <= pend_d;
    end
  end

  // Sequencing: decide whether this cycle freezes or runs, and what redirect applies.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    pend_d    = pend_q;
    do_freeze = 1'b0;
    do_run    = 1'b0;
    redir     = 1'b0;
    mem_err   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (mem_wait) begin
          do_freeze = 1'b1;
          state_d   = MEMWAIT;
          wd_d      = 8'd1;
          pend_d    = redirectE;
        end else begin
          do_run = 1'b1;
          redir  = redirectE;
        end
      end
      MEMWAIT: begin
        if (dmem_ackM || wd_hit) begin
          // An ack coinciding with the timeout is a normal completion.
          mem_err = !dmem_ackM;
          do_run  = 1'b1;
          redir   = redirectE || pend_q;
          state_d = RUN;
          wd_d    = 8'd0;
          pend_d  = 1'b0;
        end else begin
          do_freeze = 1'b1;
          wd_d      = wd_q + 8'd1;
          pend_d    = pend_q || redirectE;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Strobes; sclr wins over en at the stage register.
  always_comb begin
    pc_en     = 1'b1;
    enFD      = 1'b1;
    enDE      = 1'b1;
    enEM      = 1'b1;
    enMW      = 1'b1;
    sclrFD    = 1'b0;
    sclrDE    = 1'b0;
    sclrEM    = 1'b0;
    sclrMW    = 1'b0;
    redir_app = 1'b0;
    if (state_q == BOOT) begin
      pc_en  = 1'b0;
      enFD   = 1'b0;
      enDE   = 1'b0;
      enEM   = 1'b0;
      enMW   = 1'b0;
      sclrFD = 1'b1;
      sclrDE = 1'b1;
      sclrEM = 1'b1;
      sclrMW = 1'b1;
    end else if (do_freeze) begin
      pc_en  = 1'b0;
      enFD   = 1'b0;
      enDE   = 1'b0;
      enEM   = 1'b0;
      sclrMW = 1'b1;
    end else if (do_run) begin
      // Redirect outranks load-use and fetch bubbles: that work is wrong-path.
      if (redir) begin
        sclrFD    = 1'b1;
        sclrDE    = 1'b1;
        redir_app = 1'b1;
      end else if (load_use) begin
        pc_en  = 1'b0;
        enFD   = 1'b0;
        sclrDE = 1'b1;
      end else if (!imem_validF) begin
        pc_en  = 1'b0;
        sclrFD = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      stall_cyc <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!pc_en && (state_q != BOOT)) stall_cyc <= stall_cyc + 32'd1;
      if (redir_app)                   flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  logic unused_redir_app;
  assign unused_redir_app = redir_app;
`endif

endmodule
